// File: rtl/c_regresivo_mmss_pkg.sv
// Shared definitions for the MM:SS countdown timer: FSM encoding,
// digit maxima and the preset clamp helper.
package c_regresivo_mmss_pkg;

  // Timer control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Largest legal value of a units digit and of a tens digit.
  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  // Number of BCD digits in the MM:SS display.
  localparam int N_DIGITS = 4;

  // Saturate an out-of-range preset digit to the digit's maximum.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d,
                                             input logic [3:0] max_v);
    return (d > max_v) ? max_v : d;
  endfunction

endpackage

// File: rtl/c_digito_desc.sv
// One BCD down-counting digit. Wraps 0 -> MAX on a decrement and raises
// borrow in that same cycle so the next digit up can follow.
module c_digito_desc
  import c_regresivo_mmss_pkg::*;
#(
  parameter logic [3:0] MAX = UNITS_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] d_in,
  input  logic       dec,
  output logic [3:0] q,
  output logic       borrow
);

  logic [3:0] value_q;
  logic [3:0] value_d;

  // Next digit value: load wins over decrement; decrement wraps at 0.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = clamp_digit(d_in, MAX);
    end else if (dec) begin
      value_d = (value_q == 4'd0) ? MAX : value_q - 4'd1;
    end
  end

  // Digit register, updated on the falling edge like the rest of the timer.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      value_q <= 4'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign q      = value_q;
  assign borrow = dec && (value_q == 4'd0);

endmodule

// File: rtl/c_regresivo_mmss.sv
// MM:SS countdown timer. Four chained BCD digits are decremented by the
// seconds tick while in RUN; reaching 00:00 passes through FIN, which
// produces a one-cycle done pulse on the following edge.
module c_regresivo_mmss
  import c_regresivo_mmss_pkg::*;
#(
  parameter int TICK_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] pre_md,
  input  logic [3:0] pre_mu,
  input  logic [3:0] pre_sd,
  input  logic [3:0] pre_su,
  output logic [3:0] salida_md,
  output logic [3:0] salida_mu,
  output logic [3:0] salida_sd,
  output logic [3:0] salida_su,
  output logic       running,
  output logic       zero,
  output logic       done
);

  state_t     state_q;
  state_t     state_d;
  logic       done_q;

  logic       tick_eff;
  logic       load_en;
  logic       run_dec;
  logic       cnt_one;

  // Digit index 0 = seconds units ... 3 = minute tens.
  logic [3:0] pre_arr   [N_DIGITS];
  logic [3:0] digit_q   [N_DIGITS];
  logic [N_DIGITS-1:0] dec_chain;
  logic [N_DIGITS-1:0] borrow;

  // With the prescaler bypassed every clock edge is a one-second step.
  assign tick_eff = (TICK_EN == 0) ? 1'b1 : tick;

  assign pre_arr[0] = pre_su;
  assign pre_arr[1] = pre_sd;
  assign pre_arr[2] = pre_mu;
  assign pre_arr[3] = pre_md;

  // Commands decoded with stop > load > start > tick priority. Load is only
  // honoured in IDLE; the count is only decremented in RUN and never from
  // 00:00, so the minute-tens digit cannot wrap below zero.
  assign load_en = (state_q == ST_IDLE) && !stop && load;
  assign run_dec = (state_q == ST_RUN) && !stop && tick_eff && !zero;

  assign dec_chain[0] = run_dec;

  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      c_digito_desc #(
        .MAX((gi % 2 == 0) ? UNITS_MAX : TENS_MAX)
      ) u_digit (
        .clk    (clk),
        .rst    (rst),
        .load   (load_en),
        .d_in   (pre_arr[gi]),
        .dec    (dec_chain[gi]),
        .q      (digit_q[gi]),
        .borrow (borrow[gi])
      );
      if (gi < N_DIGITS - 1) begin : g_chain
        assign dec_chain[gi+1] = borrow[gi];
      end
    end
  endgenerate

  assign zero    = (digit_q[3] == 4'd0) && (digit_q[2] == 4'd0) &&
                   (digit_q[1] == 4'd0) && (digit_q[0] == 4'd0);
  // 00:01 is the last value before expiry; the decrement from it ends the run.
  assign cnt_one = (digit_q[3] == 4'd0) && (digit_q[2] == 4'd0) &&
                   (digit_q[1] == 4'd0) && (digit_q[0] == 4'd1);

  // Next-state logic for IDLE / RUN / FIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // A load in the same cycle as start takes precedence; start waits.
        if (!stop && !load && start && !zero) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tick_eff && (cnt_one || zero || borrow[N_DIGITS-1])) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register and done pulse; done follows the single FIN cycle.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_FIN);
    end
  end

  assign salida_su = digit_q[0];
  assign salida_sd = digit_q[1];
  assign salida_mu = digit_q[2];
  assign salida_md = digit_q[3];
  assign running   = (state_q == ST_RUN);
  assign done      = done_q;

endmodule
